d_mem_arb_wrap: RTL and testbench
=================================

# d_mem_arb_wrap

Parametrised data-memory wrap that shares one single-port, byte-enabled data memory between the core pipeline (Q103H request, Q104H read data) and the fabric-to-core (F2C) port. The core has priority. Fabric requests wait in a one-entry holding buffer and are guaranteed service by a starvation counter that stalls the core when the limit is reached. The block sits beside the CR block in each core tile and replaces the fixed-size, unarbitrated data-memory wrap.

## Interface
- D_MEM_AW, 10, word-address bits; memory holds 2**D_MEM_AW 32-bit words.
- STARVE_MAX, 4, maximum consecutive cycles a pending fabric request may be denied.
- QClk  in  1  core clock; all state updates on its rising edge.
- RstQnnnL  in  1  reset; asynchronous, active-low.
- CoreIdStrap  in  8  this tile's core id.
- AddressQ103H  in  32  core byte address.
  - [31:24] core id; 0 or CoreIdStrap means local.
  - [23:22] region; 2'b01 is the data-memory region.
  - [D_MEM_AW+1:2] word index.
- ByteEnQ103H  in  4  core byte enables for writes.
- WrDataQ103H  in  32  core write data.
- RdEnQ103H  in  1  core read request.
- WrEnQ103H  in  1  core write request.
- CoreStallQ103H  out  1  core request not accepted this cycle; core holds all Q103H inputs.
- MemRdDataQ104H  out  32  core read data.
- F2C_ValidQ503H  in  1  fabric request valid.
- F2C_ReadyQ503H  out  1  holding buffer empty.
- F2C_AddressQ503H  in  32  fabric byte address; word index [D_MEM_AW+1:2]; no region or core-id check.
- F2C_WrEnQ503H  in  1  1 = full-word write, 0 = read.
- F2C_WrDataQ503H  in  32  fabric write data.
- F2C_RdValidQ504H  out  1  one-cycle pulse; fabric read data valid.
- F2C_MemRdDataQ504H  out  32  fabric read data.

## Operation
- Core hit: (RdEnQ103H | WrEnQ103H) and local core id and data-memory region. Non-hits never touch memory.
- Fabric accept: F2C_ValidQ503H & F2C_ReadyQ503H at the clock edge. The buffer captures address, write flag and data.
- F2C_ReadyQ503H equals !buffer_valid.
  - There is no same-cycle refill.
  - Peak fabric throughput is one request per 2 cycles.
- Arbitration is evaluated each cycle while the buffer is valid.
  - Fabric is granted if there is no core hit, or if starve_cnt == STARVE_MAX.
  - Otherwise the core is granted and starve_cnt increments.
  - A fabric grant clears buffer_valid and starve_cnt.
- CoreStallQ103H = core hit & fabric grant (combinational). A stalled core request performs no memory access.
- Memory writes:
  - Core writes apply only the lanes enabled in ByteEnQ103H.
  - Fabric writes apply all 4 lanes.
  - Write data is visible to a read issued on the next cycle.
- Reads are synchronous.
  - Data is registered into MemRdDataQ104H or F2C_MemRdDataQ504H one cycle after the grant.
- MemRdDataQ104H:
  - Memory data if the previous cycle had a granted core read hit.
  - Otherwise 32'b0, including out-of-region reads, remote-core reads, writes and stalled cycles.
- F2C_RdValidQ504H pulses one cycle after a fabric read grant. No pulse follows a fabric write.
- Memory contents are not reset.

## Timing
- Reset values:
  - F2C_ReadyQ503H = 1 (buffer empty, starve_cnt = 0).
  - F2C_RdValidQ504H = 0.
  - MemRdDataQ104H = 0.
  - F2C_MemRdDataQ504H = 0.
  - CoreStallQ103H = 0.
- Core read latency: request in cycle T, data in T+1. There is no stall unless a fabric grant is forced.
- Fabric read, idle core:
  - Accepted at edge ending T.
  - Granted in T+1.
  - F2C_RdValidQ504H in T+2.
  - Ready again in T+2.
- Fabric read, continuous core hits:
  - Denied in T+1..T+STARVE_MAX.
  - Granted in T+STARVE_MAX+1 with CoreStallQ103H = 1.
  - Data in T+STARVE_MAX+2.
- starve_cnt is STARVE_MAX-width clamped. It never exceeds STARVE_MAX and never wraps.
- Core write and fabric write in the same cycle: only the granted one commits; the stalled one retries.
- Reset asserted mid-operation:
  - A pending fabric request is dropped.
  - No F2C_RdValidQ504H pulse occurs.
  - Outputs take reset values immediately (asynchronous).
  - The first accept after deassertion behaves as from idle.
- Core hit with empty buffer: never stalled.

## Test plan
- Core write 0xDEADBEEF to word 5 (BE=4'hF), then write 0x000000AA with BE=4'h1, then read word 5. Required: MemRdDataQ104H = 0xDEADBEAA one cycle after the read; CoreStallQ103H stays 0 throughout.
- Read with address core id 0x07 when CoreIdStrap = 0x03, and separately a read in region 2'b10. Required: MemRdDataQ104H = 0 and memory is unchanged.
- Idle core; fabric writes 0x12345678 to word 9, then reads word 9. Required: ready drops for exactly 1 cycle per request; F2C_RdValidQ504H pulses 2 cycles after the read accept with 0x12345678.
- Core issues a read hit every cycle while a fabric read is pending, STARVE_MAX = 4. Required: core is served for 4 cycles; stall is asserted on the 5th; F2C_RdValidQ504H fires on the 6th; the core's held request completes on the 6th.
- Simultaneous core write and fabric write to the same word under forced starvation. Required: fabric data is committed first, then the core write; the final read returns the core data.
- Assert RstQnnnL for one cycle while a fabric read is pending. Required: no RdValid pulse; ready = 1 in the same cycle; a subsequent fabric read completes with idle-case latency.

Source files
------------

// File: rtl/d_mem_arb_wrap.sv
// rtl/d_mem_arb_wrap.sv - data-memory wrap shared between core pipeline and fabric port
//
// Purpose: one single-port, byte-enabled data memory shared by the core
// (Q103H request / Q104H data) and the fabric-to-core port. The core has
// priority; a fabric request waits in a one-entry holding buffer and is
// forced through after STARVE_MAX consecutive denials.
//
// Ports:
//   QClk, RstQnnnL          clock, asynchronous active-low reset
//   CoreIdStrap             this tile's core id
//   AddressQ103H, ByteEnQ103H, WrDataQ103H, RdEnQ103H, WrEnQ103H
//                           core request
//   CoreStallQ103H          core request not accepted this cycle
//   MemRdDataQ104H          core read data (zero unless a granted read hit)
//   F2C_ValidQ503H/ReadyQ503H, F2C_AddressQ503H, F2C_WrEnQ503H, F2C_WrDataQ503H
//                           fabric request handshake
//   F2C_RdValidQ504H, F2C_MemRdDataQ504H
//                           fabric read response

module d_mem_arb_wrap #(
    parameter int D_MEM_AW   = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic        QClk,
    input  logic        RstQnnnL,
    input  logic [7:0]  CoreIdStrap,
    input  logic [31:0] AddressQ103H,
    input  logic [3:0]  ByteEnQ103H,
    input  logic [31:0] WrDataQ103H,
    input  logic        RdEnQ103H,
    input  logic        WrEnQ103H,
    output logic        CoreStallQ103H,
    output logic [31:0] MemRdDataQ104H,
    input  logic        F2C_ValidQ503H,
    output logic        F2C_ReadyQ503H,
    input  logic [31:0] F2C_AddressQ503H,
    input  logic        F2C_WrEnQ503H,
    input  logic [31:0] F2C_WrDataQ503H,
    output logic        F2C_RdValidQ504H,
    output logic [31:0] F2C_MemRdDataQ504H
);

    localparam int DEPTH = 1 << D_MEM_AW;
    localparam int SCW   = $clog2(STARVE_MAX + 1);

    logic [31:0]         mem [DEPTH];
    logic [31:0]         mem_q;

    logic                buf_valid;
    logic [D_MEM_AW-1:0] buf_addr;
    logic                buf_wr;
    logic [31:0]         buf_data;
    logic [SCW-1:0]      starve_cnt;

    logic                core_local;
    logic                core_hit;
    logic                starve_at_max;
    logic                fab_grant;
    logic                core_grant;
    logic                core_rd_q;
    logic                fab_rd_q;

    logic                mem_en;
    logic                mem_we;
    logic [3:0]          mem_be;
    logic [D_MEM_AW-1:0] mem_idx;
    logic [31:0]         mem_wdata;

    // Address bits that do not take part in decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AddressQ103H[21:D_MEM_AW+2], AddressQ103H[1:0],
                                F2C_AddressQ503H[31:D_MEM_AW+2], F2C_AddressQ503H[1:0]};

    // Core id 0 is an alias for "this tile".
    assign core_local    = (AddressQ103H[31:24] == 8'h00) || (AddressQ103H[31:24] == CoreIdStrap);
    assign core_hit      = (RdEnQ103H || WrEnQ103H) && core_local && (AddressQ103H[23:22] == 2'b01);
    assign starve_at_max = (starve_cnt == SCW'(STARVE_MAX));
    assign fab_grant     = buf_valid && (!core_hit || starve_at_max);
    assign core_grant    = core_hit && !fab_grant;

    assign CoreStallQ103H = core_hit && fab_grant;
    assign F2C_ReadyQ503H = !buf_valid;

    // Single memory port, steered to whichever requester won this cycle.
    assign mem_en    = fab_grant || core_grant;
    assign mem_we    = fab_grant ? buf_wr   : (core_grant && WrEnQ103H);
    assign mem_be    = fab_grant ? 4'hF     : ByteEnQ103H;
    assign mem_idx   = fab_grant ? buf_addr : AddressQ103H[D_MEM_AW+1:2];
    assign mem_wdata = fab_grant ? buf_data : WrDataQ103H;

    // Contents are intentionally not reset; read returns pre-write data.
    always_ff @(posedge QClk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we && mem_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            mem_q <= mem[mem_idx];
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_wr     <= 1'b0;
            buf_data   <= '0;
            starve_cnt <= '0;
            core_rd_q  <= 1'b0;
            fab_rd_q   <= 1'b0;
        end else begin
            core_rd_q <= core_grant && RdEnQ103H;
            fab_rd_q  <= fab_grant && !buf_wr;
            if (fab_grant) begin
                buf_valid  <= 1'b0;
                starve_cnt <= '0;
            end else if (buf_valid) begin
                // Denied this cycle; saturating so it can never wrap.
                if (!starve_at_max) begin
                    starve_cnt <= starve_cnt + SCW'(1);
                end
            end else if (F2C_ValidQ503H) begin
                buf_valid <= 1'b1;
                buf_addr  <= F2C_AddressQ503H[D_MEM_AW+1:2];
                buf_wr    <= F2C_WrEnQ503H;
                buf_data  <= F2C_WrDataQ503H;
            end
        end
    end

    // Flags gate the shared read register so each side sees only its own data.
    assign MemRdDataQ104H     = core_rd_q ? mem_q : 32'h0;
    assign F2C_RdValidQ504H   = fab_rd_q;
    assign F2C_MemRdDataQ504H = fab_rd_q ? mem_q : 32'h0;

endmodule

// File: tb/tb_d_mem_arb_wrap.sv
// tb/tb_d_mem_arb_wrap.sv - self-checking bench for d_mem_arb_wrap

module tb_d_mem_arb_wrap;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  core_id;
    logic [31:0] c_addr;
    logic [3:0]  c_be;
    logic [31:0] c_wdata;
    logic        c_rd;
    logic        c_wr;
    logic        stall;
    logic [31:0] rd_q104;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_addr;
    logic        f_wr;
    logic [31:0] f_wdata;
    logic        f_rdv;
    logic [31:0] f_rdata;

    int checks   = 0;
    int failures = 0;

    // Reference model state: word contents, pending fabric request, denial count.
    logic [31:0] m_mem [32];
    logic        m_pend;
    int          m_paddr;
    logic        m_pwr;
    logic [31:0] m_pdata;
    int          m_wait;
    logic [31:0] n_core;
    logic        n_fv;
    logic [31:0] n_fd;
    logic        last_stall;

    d_mem_arb_wrap #(.D_MEM_AW(10), .STARVE_MAX(STARVE_MAX)) dut (
        .QClk               (clk),
        .RstQnnnL           (rst_n),
        .CoreIdStrap        (core_id),
        .AddressQ103H       (c_addr),
        .ByteEnQ103H        (c_be),
        .WrDataQ103H        (c_wdata),
        .RdEnQ103H          (c_rd),
        .WrEnQ103H          (c_wr),
        .CoreStallQ103H     (stall),
        .MemRdDataQ104H     (rd_q104),
        .F2C_ValidQ503H     (f_valid),
        .F2C_ReadyQ503H     (f_ready),
        .F2C_AddressQ503H   (f_addr),
        .F2C_WrEnQ503H      (f_wr),
        .F2C_WrDataQ503H    (f_wdata),
        .F2C_RdValidQ504H   (f_rdv),
        .F2C_MemRdDataQ504H (f_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] caddr(input logic [7:0] id, input logic [1:0] rg, input int w);
        logic [9:0] wi;
        wi = w[9:0];
        return {id, rg, 10'b0, wi, 2'b00};
    endfunction

    task automatic set_core(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        c_rd = rd; c_wr = wr; c_addr = a; c_be = be; c_wdata = d;
    endtask

    task automatic set_fab(input logic v, input logic wr, input int w, input logic [31:0] d);
        f_valid = v; f_wr = wr; f_addr = caddr(8'h00, 2'b00, w); f_wdata = d;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model,
    // then check registered outputs just after the edge.
    task automatic cycle();
        logic hit, fg;
        int   w;
        @(negedge clk);
        hit = (c_rd || c_wr) && (c_addr[31:24] == 8'h00 || c_addr[31:24] == core_id)
              && (c_addr[23:22] == 2'b01);
        fg  = m_pend && (!hit || m_wait == STARVE_MAX);
        chk("core_stall", {31'b0, stall}, {31'b0, hit && fg});
        chk("f2c_ready", {31'b0, f_ready}, {31'b0, !m_pend});
        last_stall = stall;
        w      = int'(c_addr[6:2]);
        n_core = (hit && !fg && c_rd) ? m_mem[w] : 32'h0;
        n_fv   = fg && !m_pwr;
        n_fd   = m_mem[m_paddr];
        if (fg) begin
            if (m_pwr) m_mem[m_paddr] = m_pdata;
            m_pend = 1'b0;
            m_wait = 0;
        end else if (m_pend) begin
            m_wait++;
        end else if (f_valid) begin
            m_pend  = 1'b1;
            m_paddr = int'(f_addr[6:2]);
            m_pwr   = f_wr;
            m_pdata = f_wdata;
        end
        if (hit && !fg && c_wr) begin
            for (int b = 0; b < 4; b++)
                if (c_be[b]) m_mem[w][8*b +: 8] = c_wdata[8*b +: 8];
        end
        @(posedge clk);
        #1;
        chk("core_rdata", rd_q104, n_core);
        chk("f2c_rdvalid", {31'b0, f_rdv}, {31'b0, n_fv});
        if (n_fv) chk("f2c_rdata", f_rdata, n_fd);
    endtask

    int stall_at;
    int rdv_at;
    logic stall_any;
    logic [1:0] rg;
    logic [7:0] id;

    initial begin
        rst_n = 1'b0; core_id = 8'h03;
        set_core(0, 0, 32'h0, 4'h0, 32'h0);
        set_fab(0, 0, 0, 32'h0);
        m_pend = 0; m_paddr = 0; m_pwr = 0; m_pdata = 0; m_wait = 0; last_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, f_ready}, 32'd1);
        chk("rst_rdvalid", {31'b0, f_rdv}, 32'd0);
        chk("rst_core_rdata", rd_q104, 32'h0);
        chk("rst_f2c_rdata", f_rdata, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        rst_n = 1'b1;

        // Give every word the bench uses a known value.
        for (int w = 0; w < 32; w++) begin
            set_core(0, 1, caddr(8'h00, 2'b01, w), 4'hF, $urandom);
            cycle();
        end

        // Byte-lane merge on core writes.
        stall_any = 0;
        set_core(0, 1, caddr(8'h00, 2'b01, 5), 4'hF, 32'hDEADBEEF); cycle(); stall_any |= last_stall;
        set_core(0, 1, caddr(8'h03, 2'b01, 5), 4'h1, 32'h000000AA); cycle(); stall_any |= last_stall;
        set_core(1, 0, caddr(8'h00, 2'b01, 5), 4'h0, 32'h0);        cycle(); stall_any |= last_stall;
        chk("be_merge_read", rd_q104, 32'hDEADBEAA);
        chk("be_merge_nostall", {31'b0, stall_any}, 32'd0);

        // Remote core id and wrong region never touch memory.
        set_core(1, 0, caddr(8'h07, 2'b01, 5), 4'h0, 32'h0);        cycle();
        chk("remote_read_zero", rd_q104, 32'h0);
        set_core(1, 0, caddr(8'h00, 2'b10, 5), 4'h0, 32'h0);        cycle();
        chk("region_read_zero", rd_q104, 32'h0);
        set_core(0, 1, caddr(8'h07, 2'b01, 5), 4'hF, 32'h11111111); cycle();
        set_core(0, 1, caddr(8'h00, 2'b11, 5), 4'hF, 32'h22222222); cycle();
        set_core(1, 0, caddr(8'h00, 2'b01, 5), 4'h0, 32'h0);        cycle();
        chk("nonhit_mem_unchanged", rd_q104, 32'hDEADBEAA);
        set_core(0, 0, 32'h0, 4'h0, 32'h0);

        // Fabric write then read with idle core.
        set_fab(1, 1, 9, 32'h12345678); cycle();
        set_fab(0, 0, 0, 32'h0);
        chk("fab_wr_ready_low", {31'b0, f_ready}, 32'd0);
        cycle();
        chk("fab_wr_ready_back", {31'b0, f_ready}, 32'd1);
        set_fab(1, 0, 9, 32'h0); cycle();
        set_fab(0, 0, 0, 32'h0); cycle();
        chk("fab_rd_pulse", {31'b0, f_rdv}, 32'd1);
        chk("fab_rd_data", f_rdata, 32'h12345678);

        // Fabric read starved by continuous core read hits.
        set_fab(1, 0, 9, 32'h0); cycle();
        set_fab(0, 0, 0, 32'h0);
        set_core(1, 0, caddr(8'h00, 2'b01, 5), 4'h0, 32'h0);
        stall_at = 0; rdv_at = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            if (last_stall && stall_at == 0) stall_at = i;
            if (f_rdv && rdv_at == 0) rdv_at = i + 1;
        end
        chk("starve_stall_cycle", stall_at, 32'd5);
        chk("starve_rdvalid_cycle", rdv_at, 32'd6);
        chk("starve_core_completes", rd_q104, 32'hDEADBEAA);
        set_core(0, 0, 32'h0, 4'h0, 32'h0);

        // Colliding writes under forced starvation: fabric first, then core.
        set_fab(1, 1, 7, 32'hA5A5A5A5); cycle();
        set_fab(0, 0, 0, 32'h0);
        set_core(0, 1, caddr(8'h00, 2'b01, 7), 4'hF, 32'h5A5A0001);
        stall_at = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            if (last_stall && stall_at == 0) stall_at = i;
        end
        chk("collide_stall_cycle", stall_at, 32'd5);
        set_core(1, 0, caddr(8'h00, 2'b01, 7), 4'h0, 32'h0); cycle();
        chk("collide_final", rd_q104, 32'h5A5A0001);
        set_core(0, 0, 32'h0, 4'h0, 32'h0);

        // Reset while a fabric read is pending.
        set_fab(1, 0, 9, 32'h0); cycle();
        set_fab(0, 0, 0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, f_ready}, 32'd1);
        chk("midrst_rdvalid", {31'b0, f_rdv}, 32'd0);
        m_pend = 0; m_wait = 0;
        @(posedge clk);
        #1;
        chk("midrst_no_pulse", {31'b0, f_rdv}, 32'd0);
        rst_n = 1'b1;
        cycle();
        set_fab(1, 0, 9, 32'h0); cycle();
        set_fab(0, 0, 0, 32'h0); cycle();
        chk("postrst_rd_pulse", {31'b0, f_rdv}, 32'd1);
        chk("postrst_rd_data", f_rdata, 32'h12345678);

        // Randomised traffic against the model; a stalled core holds its request.
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                rg = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0: id = 8'h00;
                    1: id = 8'h07;
                    default: id = 8'h03;
                endcase
                set_core(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         caddr(id, rg, $urandom_range(0, 31)), 4'($urandom), $urandom);
            end
            set_fab(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 31), $urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
